// File: rtl/mock_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mock_uart_pkg
// Purpose  : Shared register map, status bit layout and FSM encoding for the
//            mock UART receive model.
// Revision : 1.0 - initial release
// ============================================================================
package mock_uart_pkg;

    localparam logic [31:0] c_rxfifo_addr_def = 32'hC000_0000;
    localparam logic [31:0] c_txfifo_addr_def = 32'hC000_0004;
    localparam logic [31:0] c_status_addr_def = 32'hC000_0008;
    localparam logic [31:0] c_unmapped_data   = 32'hDEAD_BEEF;

    localparam int unsigned c_STAT_RX_VALID   = 0;
    localparam int unsigned c_STAT_RX_FULL    = 1;
    localparam int unsigned c_STAT_TX_EMPTY   = 2;
    localparam int unsigned c_STAT_TX_FULL    = 3;
    localparam int unsigned c_STAT_RX_OVERRUN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The TX side is not modelled, so it always reports empty and never full.
    function automatic logic [7:0] status_byte(input logic rx_valid,
                                               input logic rx_full,
                                               input logic rx_overrun);
        logic [7:0] s;
        s                    = '0;
        s[c_STAT_RX_VALID]   = rx_valid;
        s[c_STAT_RX_FULL]    = rx_full;
        s[c_STAT_TX_EMPTY]   = 1'b1;
        s[c_STAT_TX_FULL]    = 1'b0;
        s[c_STAT_RX_OVERRUN] = rx_overrun;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Synchronous FIFO with first-word-fall-through head and occupancy
//            count; push is refused when full, pop is refused when empty.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_PTR_W:0]   count_q;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    assign w_full  = (count_q == (c_PTR_W + 1)'(DEPTH));
    assign w_empty = (count_q == '0);
    // A full FIFO never accepts a push, even if a pop happens on the same edge.
    assign w_push  = push_i && !w_full;
    assign w_pop   = pop_i && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (c_PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (c_PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mock_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : mock_uart_rx
// Purpose  : Bus-slave model of a UART receiver with fixed access latency and
//            a host-fed RX FIFO. Optional MOCK_UART_RX_LOOPBACK_EN routes
//            TXFIFO writes back into the RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mock_uart_rx
    import mock_uart_pkg::*;
#(
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          RX_FIFO_DEPTH      = 16,
    parameter int          AXI_LATENCY        = 10,
    parameter logic [31:0] UART_RXFIFO_ADDR   = c_rxfifo_addr_def,
    parameter logic [31:0] UART_TXFIFO_ADDR   = c_txfifo_addr_def,
    parameter logic [31:0] UART_STATUS_ADDR   = c_status_addr_def
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            M_DEVICE_strobe,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_DEVICE_addr,
    input  logic                            M_DEVICE_rw,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_DEVICE_byte_enable,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_DEVICE_core2dev_data,
    output logic                            M_DEVICE_data_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_DEVICE_dev2core_data,
    input  logic                            host_rx_valid,
    input  logic [7:0]                      host_rx_data,
    output logic                            host_rx_ready,
    output logic                            rx_overrun
);

    localparam int c_DW    = C_M_AXI_DATA_WIDTH;
    localparam int c_LAT_W = (AXI_LATENCY > 1) ? $clog2(AXI_LATENCY) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(AXI_LATENCY - 1);
    localparam logic [c_DW-1:0]    c_RX_ADDR  = c_DW'(UART_RXFIFO_ADDR);
    localparam logic [c_DW-1:0]    c_TX_ADDR  = c_DW'(UART_TXFIFO_ADDR);
    localparam logic [c_DW-1:0]    c_ST_ADDR  = c_DW'(UART_STATUS_ADDR);

    // The state register itself records the latched rw direction.
    state_e                     state_q;
    logic [c_LAT_W-1:0]         lat_cnt_q;
    logic [c_DW-1:0]            addr_q;
    logic [c_DW-1:0]            wdata_q;
    logic                       data_ready_q;
    logic [c_DW-1:0]            rdata_q;
    logic                       overrun_q;

    logic                       w_rd_done;
    logic                       w_wr_done;
    logic                       w_hit_rx;
    logic                       w_hit_tx;
    logic                       w_hit_st;
    logic                       w_lb_push;
    logic                       w_host_ready;
    logic                       w_fifo_push;
    logic [7:0]                 w_fifo_din;
    logic                       w_fifo_pop;
    logic [7:0]                 w_fifo_head;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(RX_FIFO_DEPTH):0] w_rx_count;
    logic [c_DW-1:0]            w_rd_data;
    logic                       w_unused;

    assign w_hit_rx  = (addr_q == c_RX_ADDR);
    assign w_hit_tx  = (addr_q == c_TX_ADDR);
    assign w_hit_st  = (addr_q == c_ST_ADDR);
    assign w_rd_done = (state_q == READ)  && (lat_cnt_q == c_LAT_LAST);
    assign w_wr_done = (state_q == WRITE) && (lat_cnt_q == c_LAT_LAST);

`ifdef MOCK_UART_RX_LOOPBACK_EN
    assign w_lb_push = w_wr_done && w_hit_tx;
`else
    assign w_lb_push = 1'b0;
`endif

    // Loopback owns the FIFO write port on its cycle, so the host is stalled.
    assign w_host_ready = !w_full && !w_lb_push;
    assign w_fifo_push  = w_lb_push || (host_rx_valid && w_host_ready);
    assign w_fifo_din   = w_lb_push ? wdata_q[7:0] : host_rx_data;
    assign w_fifo_pop   = w_rd_done && w_hit_rx && !w_empty;

    always_comb begin
        w_rd_data = c_DW'(c_unmapped_data);
        if (w_hit_rx) begin
            w_rd_data = w_empty ? '0 : c_DW'(w_fifo_head);
        end else if (w_hit_st) begin
            w_rd_data = c_DW'(status_byte(!w_empty, w_full, overrun_q));
        end
    end

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_fifo_push),
        .data_i  (w_fifo_din),
        .pop_i   (w_fifo_pop),
        .data_o  (w_fifo_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_rx_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_ready_q <= 1'b0;
            rdata_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (M_DEVICE_strobe) begin
                        addr_q    <= M_DEVICE_addr;
                        wdata_q   <= M_DEVICE_core2dev_data;
                        lat_cnt_q <= '0;
                        state_q   <= M_DEVICE_rw ? WRITE : READ;
                    end
                end
                READ, WRITE: begin
                    if (lat_cnt_q == c_LAT_LAST) begin
                        state_q      <= DONE;
                        data_ready_q <= 1'b1;
                        if (state_q == READ) begin
                            rdata_q <= w_rd_data;
                            if (w_hit_st) begin
                                overrun_q <= 1'b0;
                            end
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q + c_LAT_W'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A loopback byte arriving at a full FIFO is lost and flagged.
            if (w_lb_push && w_full) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign M_DEVICE_data_ready    = data_ready_q;
    assign M_DEVICE_dev2core_data = rdata_q;
    assign host_rx_ready          = w_host_ready;
    assign rx_overrun             = overrun_q;

    assign w_unused = ^{M_DEVICE_byte_enable, wdata_q, w_rx_count, w_hit_tx};

endmodule
`default_nettype wire

// File: doc/mock_uart_rx.md
MOCK_UART_RX -- requirements
Module: mock_uart_rx

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, device bus data/address width.
REQ-002 SHALL have parameter RX_FIFO_DEPTH, default 16, RX FIFO entries; a power of two, at least 2.
REQ-003 SHALL have parameter AXI_LATENCY, default 10, emulated bus latency in cycles; at least 1.
REQ-004 SHALL have parameters UART_RXFIFO_ADDR, UART_TXFIFO_ADDR and UART_STATUS_ADDR, defaults 32'hC0000000, 32'hC0000004 and 32'hC0000008, register addresses.
REQ-005 SHALL have port clk, input, 1 bit, clock; rst_n, input, 1 bit: reset rst_n, synchronous, active-low; clock clk.
REQ-006 SHALL have port M_DEVICE_strobe, input, 1 bit, request start.
REQ-007 SHALL have port M_DEVICE_addr, input, C_M_AXI_DATA_WIDTH bits, address; M_DEVICE_rw, input, 1 bit, 1 = write.
REQ-008 SHALL have port M_DEVICE_byte_enable, input, C_M_AXI_DATA_WIDTH/8 bits, ignored.
REQ-009 SHALL have port M_DEVICE_core2dev_data, input, C_M_AXI_DATA_WIDTH bits, write data.
REQ-010 SHALL have port M_DEVICE_data_ready, output, 1 bit, completion pulse; M_DEVICE_dev2core_data, output, C_M_AXI_DATA_WIDTH bits, read data.
REQ-011 SHALL have ports host_rx_valid, input, 1 bit; host_rx_data, input, 8 bits; host_rx_ready, output, 1 bit: host-side byte push, used by the testbench or stdin.
REQ-012 SHALL have port rx_overrun, output, 1 bit, sticky dropped-byte flag.

Function
REQ-013 SHALL use FSM states IDLE, READ, WRITE, DONE: IDLE goes to WRITE or READ on strobe per rw; READ/WRITE goes to DONE after exactly AXI_LATENCY cycles in state; DONE goes to IDLE unconditionally.
REQ-014 SHALL latch addr, rw and core2dev_data on the IDLE strobe cycle, and SHALL ignore strobe and bus inputs in all other states.
REQ-015 SHALL drive M_DEVICE_data_ready as a register that is high only in the DONE cycle, so strobe at cycle 0 gives ready at cycle AXI_LATENCY+1.
REQ-016 SHALL load dev2core_data on the READ-to-DONE edge and hold it until the next read completes.
REQ-017 SHALL, for a read of RXFIFO: return {24'b0, head byte} and pop once if non-empty; return 0 with no pop if empty.
REQ-018 SHALL, for a read of STATUS: return bit0 rx_valid (non-empty), bit1 rx_full, bit2 tx_empty (constant 1), bit3 tx_full (constant 0), bit4 rx_overrun, other bits 0; the read clears rx_overrun on the same edge.
REQ-019 SHALL return 32'hDEADBEEF for a read of TXFIFO or any unmapped address.
REQ-020 SHALL acknowledge writes normally and, apart from the loopback feature, ignore them.
REQ-021 SHALL drive host_rx_ready = !full && !loopback_push_this_cycle, and push host_rx_data when valid && ready.
REQ-022 SHALL, on a simultaneous push and pop when not full, perform both and leave the count unchanged; when full, a pop in the same cycle does not enable a push.
REQ-023 SHALL use an occupancy count 0..RX_FIFO_DEPTH with pointer wrap modulo depth.

Reset
REQ-024 SHALL, on reset: FSM to IDLE; FIFO empty, pointers 0; data_ready 0; dev2core_data 0; rx_overrun 0; host_rx_ready 1 on the first cycle after reset.
REQ-025 SHALL, on reset mid-transaction, abandon the access and emit no data_ready.

Configuration
REQ-026 SHALL, with MOCK_UART_RX_LOOPBACK_EN defined, push core2dev_data[7:0] into the RX FIFO on the WRITE-to-DONE edge of a TXFIFO write; if the FIFO is full the byte is dropped and rx_overrun is set; the loopback push has priority over the host push.
REQ-027 SHALL, without MOCK_UART_RX_LOOPBACK_EN, discard TXFIFO writes; rx_overrun is then settable by nothing and stays 0.

Structure
REQ-028 SHALL place the address defaults, status bit indices and the FSM state enum in shared package mock_uart_pkg.
REQ-029 SHALL implement the FIFO as sub-module uart_rx_fifo (synchronous, first-word-fall-through head, count output).

Verification
REQ-030 SHALL cover: host pushes 0x41,0x42; two RXFIFO reads -> 0x41 then 0x42, each with data_ready at cycle 11 after strobe.
REQ-031 SHALL cover: STATUS read on empty FIFO -> 32'h00000004; after 16 pushes -> 32'h00000007 and host_rx_ready=0.
REQ-032 SHALL cover: RXFIFO read when empty -> 0, count stays 0; read of 32'hC0000010 -> 32'hDEADBEEF.
REQ-033 SHALL cover: FIFO at 15 entries, pop and host push on the same cycle -> count 15, order preserved across pointer wrap.
REQ-034 SHALL cover, with LOOPBACK_EN: write 0x5A to TXFIFO -> next RXFIFO read 0x5A; with FIFO full the write sets STATUS bit4, and a second STATUS read -> bit4 cleared.
REQ-035 SHALL cover: rst_n low at cycle 5 of a READ -> no data_ready, FSM in IDLE, STATUS next read 32'h00000004.
